// File: rtl/pace_pkg.sv
// Shared types and constants for the pace profile sequencer: FSM states,
// mode codes, fixed-mode periods and the hybrid segment table.
package pace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_JOG    = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_HYBRID = 2'b11;

  localparam logic [31:0] PERIOD_WALK = 32'd1562500;
  localparam logic [31:0] PERIOD_JOG  = 32'd781250;
  localparam logic [31:0] PERIOD_RUN  = 32'd390625;

  localparam int         SEG_COUNT = 11;
  localparam logic [3:0] SEG_LAST  = 4'(SEG_COUNT - 1);

  typedef struct packed {
    logic [6:0]  dur;
    logic [31:0] period;
  } seg_t;

  function automatic seg_t seg_entry(input logic [3:0] idx);
    seg_t e;
    case (idx)
      4'd0:    e = '{dur: 7'd1,  period: 32'd2500000};
      4'd1:    e = '{dur: 7'd1,  period: 32'd1515151};
      4'd2:    e = '{dur: 7'd1,  period: 32'd757575};
      4'd3:    e = '{dur: 7'd1,  period: 32'd1851851};
      4'd4:    e = '{dur: 7'd1,  period: 32'd714285};
      4'd5:    e = '{dur: 7'd1,  period: 32'd1666666};
      4'd6:    e = '{dur: 7'd1,  period: 32'd2631578};
      4'd7:    e = '{dur: 7'd2,  period: 32'd1515151};
      4'd8:    e = '{dur: 7'd64, period: 32'd724637};
      4'd9:    e = '{dur: 7'd6,  period: 32'd147058};
      4'd10:   e = '{dur: 7'd65, period: 32'd403225};
      default: e = '{dur: 7'd1,  period: 32'd0};
    endcase
    return e;
  endfunction

  function automatic logic [31:0] fixed_period(input logic [1:0] mode);
    case (mode)
      MODE_WALK: return PERIOD_WALK;
      MODE_JOG:  return PERIOD_JOG;
      MODE_RUN:  return PERIOD_RUN;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Clock divider producing a one-cycle tick on the last cycle of each
// CLK_HZ-cycle second; holds its count while disabled.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pace_profile_sequencer.sv
// Pace-mode controller: tracks run time, walks the hybrid segment table and
// hands each new half-period to the pulse generator over UPD/UPD_ACK.
module pace_profile_sequencer
  import pace_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [1:0]  MODE,
  output logic [31:0] PERIOD,
  output logic        UPD,
  input  logic        UPD_ACK,
  output logic        RUN_EN,
  output logic [3:0]  SEGMENT,
  output logic [31:0] ELAPSED,
  output logic        DONE
);

  state_e      state_q, state_d;
  logic [1:0]  mode_q;
  logic [3:0]  seg_q, seg_d;
  logic [6:0]  seg_left_q, seg_left_d;
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] period_q, period_d;
  logic        upd_q, upd_d;
  logic        run_en_q, run_en_d;
  logic        done_q, done_d;

  logic        tick;
  logic        restart;
  logic        div_en;
  logic        div_clr;
  seg_t        next_seg;

  // From IDLE a restart is START; afterwards it is any MODE change.
  always_comb begin
    restart = (state_q == ST_IDLE) ? START : (MODE != mode_q);
    div_en  = (state_q == ST_RUN) && START && !restart;
    div_clr = restart || (state_q == ST_IDLE);
  end

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    seg_left_d = seg_left_q;
    elapsed_d  = elapsed_q;
    period_d   = period_q;
    upd_d      = upd_q & ~UPD_ACK;
    done_d     = done_q;
    next_seg   = seg_entry(seg_q + 4'd1);

    if (restart) begin
      state_d    = START ? ST_RUN : ST_PAUSE;
      seg_d      = 4'd0;
      seg_left_d = seg_entry(4'd0).dur;
      elapsed_d  = 32'd0;
      period_d   = (MODE == MODE_HYBRID) ? seg_entry(4'd0).period : fixed_period(MODE);
      upd_d      = 1'b1;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!START) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 32'd1;
            if (mode_q == MODE_HYBRID) begin
              if (seg_left_q > 7'd1) begin
                seg_left_d = seg_left_q - 7'd1;
              end else if (seg_q == SEG_LAST) begin
                state_d  = ST_DONE;
                period_d = 32'd0;
                upd_d    = 1'b1;
                done_d   = 1'b1;
              end else begin
                seg_d      = seg_q + 4'd1;
                seg_left_d = next_seg.dur;
                period_d   = next_seg.period;
                upd_d      = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (START)
            state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    run_en_d = (state_d == ST_RUN) && (period_d != 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      seg_q      <= 4'd0;
      seg_left_q <= 7'd0;
      elapsed_q  <= 32'd0;
      period_q   <= 32'd0;
      upd_q      <= 1'b0;
      run_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= MODE;
      seg_q      <= seg_d;
      seg_left_q <= seg_left_d;
      elapsed_q  <= elapsed_d;
      period_q   <= period_d;
      upd_q      <= upd_d;
      run_en_q   <= run_en_d;
      done_q     <= done_d;
    end
  end

  assign PERIOD  = period_q;
  assign UPD     = upd_q;
  assign RUN_EN  = run_en_q;
  assign SEGMENT = seg_q;
  assign ELAPSED = elapsed_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_pace_profile_sequencer.sv
// Bench for pace_profile_sequencer: directed scenarios plus random traffic,
// each cycle compared against a seconds-based behavioural model.
module tb_pace_profile_sequencer;

  localparam int unsigned HZ = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        upd_ack = 1'b0;
  logic [31:0] PERIOD;
  logic        UPD;
  logic        RUN_EN;
  logic [3:0]  SEGMENT;
  logic [31:0] ELAPSED;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  pace_profile_sequencer #(.CLK_HZ(HZ)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .START   (start),
    .MODE    (mode),
    .PERIOD  (PERIOD),
    .UPD     (UPD),
    .UPD_ACK (upd_ack),
    .RUN_EN  (RUN_EN),
    .SEGMENT (SEGMENT),
    .ELAPSED (ELAPSED),
    .DONE    (DONE)
  );

  always #5 clk = ~clk;

  int dur_tab [11] = '{1, 1, 1, 1, 1, 1, 1, 2, 64, 6, 65};
  int per_tab [11] = '{2500000, 1515151, 757575, 1851851, 714285, 1666666,
                       2631578, 1515151, 724637, 147058, 403225};

  // Model state: activity started, running vs paused, counted run cycles.
  bit          m_active = 0;
  bit          m_running = 0;
  int unsigned m_cyc = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [1:0]  m_prev_mode = 2'b00;
  bit          m_upd = 0;

  function automatic int seg_of(input int unsigned secs);
    int acc = 0;
    for (int k = 0; k < 11; k++) begin
      acc += dur_tab[k];
      if (secs < acc) return k;
    end
    return 11;
  endfunction

  function automatic bit m_done();
    return m_active && (m_mode == 2'b11) && (seg_of(m_cyc / HZ) >= 11);
  endfunction

  function automatic logic [31:0] exp_period();
    if (!m_active || m_done()) return 32'd0;
    case (m_mode)
      2'b00:   return 32'd1562500;
      2'b01:   return 32'd781250;
      2'b10:   return 32'd390625;
      default: return 32'(per_tab[seg_of(m_cyc / HZ)]);
    endcase
  endfunction

  function automatic logic [31:0] exp_segment();
    if (!m_active || m_mode != 2'b11) return 32'd0;
    if (m_done()) return 32'd10;
    return 32'(seg_of(m_cyc / HZ));
  endfunction

  task automatic model_edge(input bit r, input bit s, input logic [1:0] md, input bit a);
    bit restart;
    bit ev;
    int old_seg;
    if (!r) begin
      m_active = 0; m_running = 0; m_cyc = 0; m_upd = 0;
      m_mode = 2'b00; m_prev_mode = 2'b00;
      return;
    end
    restart = !m_active ? s : (md != m_prev_mode);
    ev = 0;
    if (restart) begin
      m_active = 1; m_mode = md; m_cyc = 0; m_running = s; ev = 1;
    end else if (m_active && !m_done()) begin
      old_seg = seg_of(m_cyc / HZ);
      if (m_running && s) m_cyc++;
      if (m_mode == 2'b11 && seg_of(m_cyc / HZ) != old_seg) ev = 1;
      m_running = s;
    end
    if (ev) m_upd = 1;
    else if (a) m_upd = 0;
    m_prev_mode = md;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PERIOD", PERIOD, exp_period());
    chk("UPD", {31'd0, UPD}, {31'd0, m_upd});
    chk("RUN_EN", {31'd0, RUN_EN}, {31'd0, m_active && m_running && !m_done()});
    chk("SEGMENT", {28'd0, SEGMENT}, exp_segment());
    chk("ELAPSED", ELAPSED, m_active ? 32'(m_cyc / HZ) : 32'd0);
    chk("DONE", {31'd0, DONE}, {31'd0, m_done()});
  endtask

  task automatic step(input bit r, input bit s, input logic [1:0] md, input bit a);
    rst_n = r; start = s; mode = md; upd_ack = a;
    @(posedge clk);
    model_edge(r, s, md, a);
    #1;
    check_all();
  endtask

  logic [31:0] qp[$];
  logic [31:0] qt[$];
  logic [31:0] exp_p [12] = '{2500000, 1515151, 757575, 1851851, 714285, 1666666,
                              2631578, 1515151, 724637, 147058, 403225, 0};
  logic [31:0] exp_t [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 73, 79, 144};

  initial begin
    bit pu;
    bit r, s;
    logic [1:0] md;

    // Reset state
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0);
    chk("reset_period", PERIOD, 32'd0);
    chk("reset_upd", {31'd0, UPD}, 32'd0);

    // Walk mode start and handshake
    step(1, 1, 2'b00, 0);
    chk("walk_period", PERIOD, 32'd1562500);
    chk("walk_upd", {31'd0, UPD}, 32'd1);
    step(1, 1, 2'b00, 1);
    chk("walk_ack_drop", {31'd0, UPD}, 32'd0);
    for (int i = 0; i < 25; i++) begin
      step(1, 1, 2'b00, 0);
      chk("walk_run_en", {31'd0, RUN_EN}, 32'd1);
    end

    // Full hybrid profile, acknowledging every update
    pu = 0;
    step(1, 1, 2'b11, UPD);
    for (int i = 0; i <= 1445; i++) begin
      if (UPD === 1'b1 && !pu) begin
        qp.push_back(PERIOD);
        qt.push_back(ELAPSED);
      end
      pu = (UPD === 1'b1);
      step(1, 1, 2'b11, UPD);
    end
    chk("hyb_done", {31'd0, DONE}, 32'd1);
    chk("hyb_run_en", {31'd0, RUN_EN}, 32'd0);
    chk("hyb_elapsed", ELAPSED, 32'd144);
    chk("hyb_n_updates", 32'(qp.size()), 32'd12);
    for (int i = 0; i < 12 && i < qp.size(); i++) begin
      chk($sformatf("hyb_period_%0d", i), qp[i], exp_p[i]);
      chk($sformatf("hyb_time_%0d", i), qt[i], exp_t[i]);
    end

    // Pause at ELAPSED=5 for 37 cycles, then resume
    step(0, 0, 2'b11, 0);
    step(1, 1, 2'b11, 0);
    for (int i = 0; i < 200 && (m_cyc / HZ) < 5; i++) step(1, 1, 2'b11, UPD);
    chk("pause_reach5", ELAPSED, 32'd5);
    for (int i = 0; i < 37; i++) step(1, 0, 2'b11, UPD);
    chk("pause_elapsed", ELAPSED, 32'd5);
    chk("pause_segment", {28'd0, SEGMENT}, 32'd5);
    chk("pause_no_upd", {31'd0, UPD}, 32'd0);
    step(1, 1, 2'b11, UPD);
    for (int i = 0; i < 9; i++) step(1, 1, 2'b11, UPD);
    chk("resume_seg_before", {28'd0, SEGMENT}, 32'd5);
    step(1, 1, 2'b11, UPD);
    chk("resume_seg6", {28'd0, SEGMENT}, 32'd6);
    chk("resume_period6", PERIOD, 32'd2631578);

    // Withhold ack across two boundaries, then ack on a boundary cycle
    step(0, 0, 2'b11, 0);
    step(1, 1, 2'b11, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 2'b11, 0);
    chk("withhold_upd", {31'd0, UPD}, 32'd1);
    chk("withhold_period", PERIOD, 32'd757575);
    chk("withhold_seg", {28'd0, SEGMENT}, 32'd2);
    for (int i = 0; i < 9; i++) step(1, 1, 2'b11, 0);
    step(1, 1, 2'b11, 1);
    chk("ack_on_boundary_upd", {31'd0, UPD}, 32'd1);
    chk("ack_on_boundary_period", PERIOD, 32'd1851851);
    step(1, 1, 2'b11, 1);
    chk("ack_after_boundary", {31'd0, UPD}, 32'd0);

    // Mid-hybrid mode change to run, then a one-cycle reset
    for (int i = 0; i < 5; i++) step(1, 1, 2'b11, 0);
    step(1, 1, 2'b10, 0);
    chk("mode_chg_period", PERIOD, 32'd390625);
    chk("mode_chg_elapsed", ELAPSED, 32'd0);
    chk("mode_chg_segment", {28'd0, SEGMENT}, 32'd0);
    chk("mode_chg_upd", {31'd0, UPD}, 32'd1);
    for (int i = 0; i < 15; i++) step(1, 1, 2'b10, 0);
    step(0, 1, 2'b10, 0);
    chk("rst_period", PERIOD, 32'd0);
    chk("rst_upd", {31'd0, UPD}, 32'd0);
    chk("rst_run_en", {31'd0, RUN_EN}, 32'd0);
    chk("rst_elapsed", ELAPSED, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    step(1, 0, 2'b10, 0);
    chk("idle_period", PERIOD, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) != 0);
      s  = ($urandom_range(0, 9) != 0) ? start : ~start;
      md = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(0, 3)) : mode;
      step(r, s, md, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
